sram_pixel_streamer: RTL and testbench

Parametrised successor to the team's free-running SRAM image address counter. Streams a frame of 16-bit pixels out of the external SRAM as a valid/ready stream of 32-bit RGBA words. Adds programmable base/length, two pixel formats, loop or one-shot mode, abort, and a skid FIFO so downstream back-pressure never loses a pixel. Sits between the SRAM pins and the VGA/compositor pixel path.

---
 rtl/pixel_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/sram_pixel_streamer.sv | 166 ++++++++++++++++
 tb/tb_sram_pixel_streamer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and pixel unpack for the SRAM pixel streamer
package pixel_pkg;

  typedef enum logic {
    FMT_RGB5551 = 1'b0,
    FMT_RGB565  = 1'b1
  } pix_fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_e;

  // Channels are widened by replicating their top bits into the low bits.
  function automatic logic [31:0] unpack_pixel(input pix_fmt_e fmt, input logic [15:0] word);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
    r = {word[15:11], word[15:13]};
    if (fmt == FMT_RGB565) begin
      g = {word[10:5], word[10:9]};
      b = {word[4:0], word[4:2]};
      a = 8'hFF;
    end else begin
      g = {word[10:6], word[10:8]};
      b = {word[5:1], word[5:3]};
      a = word[0] ? 8'hFF : 8'h00;
    end
    return {r, g, b, a};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && !w_full;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_pixel_streamer.sv
// rtl/sram_pixel_streamer.sv - streams a frame of SRAM pixels as 32-bit RGBA words
module sram_pixel_streamer #(
  parameter int ADDR_W     = 20,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_frame_words,
  input  logic              i_fmt,
  input  logic              i_loop,
  inout  wire  [15:0]       io_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [31:0]       o_pix_rgba,
  output logic              o_pix_last,
  output logic              o_busy,
  output logic              o_done
);
  import pixel_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  stream_state_e     r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_words;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_sram_addr;
  pix_fmt_e          r_fmt;
  logic              r_loop;
  logic              r_done;

  logic              w_issue;
  logic              w_issue_last;
  logic              w_tag_valid;
  logic              w_tag_last;
  logic [7:0]        w_inflight;
  logic [7:0]        w_used;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_pop;
  logic [16:0]       w_fifo_data;

  assign io_sram_data = 'z;

  // Credits cover both buffered pixels and reads still in the SRAM pipe.
  assign w_used       = 8'(w_count) + w_inflight;
  assign w_issue_last = (r_offset == r_words - ONE);
  assign w_issue      = (r_state == RUN) && !i_abort && (w_used < 8'(FIFO_DEPTH));

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign w_tag_valid = w_issue;
      assign w_tag_last  = w_issue_last;
      assign w_inflight  = '0;
    end else begin : g_latn
      logic [READ_LAT-2:0] r_pv;
      logic [READ_LAT-2:0] r_pl;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_pv <= '0;
          r_pl <= '0;
        end else if (i_abort) begin
          r_pv <= '0;
          r_pl <= '0;
        end else begin
          r_pv[0] <= w_issue;
          r_pl[0] <= w_issue_last;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pl[i] <= r_pl[i-1];
          end
        end
      end

      assign w_tag_valid = r_pv[READ_LAT-2];
      assign w_tag_last  = r_pl[READ_LAT-2];
      assign w_inflight  = 8'($countones(r_pv));
    end
  endgenerate

  assign w_pop = !w_empty && i_pix_ready;

  sync_fifo #(
    .WIDTH(17),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_abort),
    .i_push  (w_tag_valid),
    .i_data  ({w_tag_last, io_sram_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_words     <= ONE;
      r_offset    <= '0;
      r_sram_addr <= '0;
      r_fmt       <= FMT_RGB5551;
      r_loop      <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_abort) begin
      r_state  <= IDLE;
      r_offset <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base      <= i_base_addr;
            r_words     <= (i_frame_words == '0) ? ONE : i_frame_words;
            r_fmt       <= pix_fmt_e'(i_fmt);
            r_loop      <= i_loop;
            r_offset    <= '0;
            r_sram_addr <= i_base_addr;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (w_issue_last) begin
              r_offset    <= '0;
              r_sram_addr <= r_base;
              if (!r_loop) begin
                r_state <= DRAIN;
              end
            end else begin
              r_offset    <= r_offset + ONE;
              r_sram_addr <= r_base + r_offset + ONE;
            end
          end
        end
        DRAIN: begin
          // The last-tagged pixel is the final one issued, so its pop empties the frame.
          if (w_pop && w_fifo_data[16]) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sram_addr = r_sram_addr;
  assign o_pix_valid = !w_empty;
  assign o_pix_last  = !w_empty && w_fifo_data[16];
  assign o_pix_rgba  = unpack_pixel(r_fmt, w_fifo_data[15:0]);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_sram_pixel_streamer.sv
// tb/tb_sram_pixel_streamer.sv - bench for sram_pixel_streamer at read latencies 1 and 3
module tb_sram_pixel_streamer;

  localparam int DEPTH = 4;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, fmt, loop, ready;
  logic [19:0] base, words;
  logic [19:0] addr  [2];
  logic        valid [2];
  logic        last  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] rgba  [2];
  wire  [15:0] bus0, bus1;
  logic [19:0] a1, a2;

  logic [15:0] ovr_word [8];
  logic [19:0] ovr_base;
  int          ovr_n;

  int checks, errors, cyc;
  bit rnd_ready, ready_hold;
  logic [31:0] got_rgba [2][256];
  bit          got_last [2][256];
  int got_n [2], issued [2], pops [2], max_out [2], done_cnt [2];
  int done_cyc [2], last_pop_cyc [2], first_valid [2];
  logic [19:0] prev_addr [2];
  logic [31:0] exp_rgba [256];
  bit          exp_last [256];
  int          exp_n;
  bit          to;

  always #5 clk = ~clk;

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    logic [19:0] off;
    logic [31:0] h;
    off = a - ovr_base;
    if (int'(off) < ovr_n) return ovr_word[off[2:0]];
    h = {12'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ h[15:0];
  endfunction

  function automatic logic [31:0] ref_rgba(input logic f, input logic [15:0] d);
    int r5, g, b, a;
    r5 = int'(d) / 2048;
    if (f) begin
      g = (int'(d) / 32) % 64;
      b = int'(d) % 32;
      a = 255;
      return {8'(r5 * 8 + r5 / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4), 8'(a)};
    end
    g = (int'(d) / 64) % 32;
    b = (int'(d) / 2) % 32;
    a = (int'(d) % 2 == 1) ? 255 : 0;
    return {8'(r5 * 8 + r5 / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4), 8'(a)};
  endfunction

  assign bus0 = sram_word(addr[0]);
  assign bus1 = sram_word(a2);
  always @(posedge clk) begin
    a1 <= addr[1];
    a2 <= a1;
  end

  sram_pixel_streamer #(.ADDR_W(20), .READ_LAT(LAT0), .FIFO_DEPTH(DEPTH)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_base_addr(base),
    .i_frame_words(words), .i_fmt(fmt), .i_loop(loop), .io_sram_data(bus0),
    .o_sram_addr(addr[0]), .o_pix_valid(valid[0]), .i_pix_ready(ready), .o_pix_rgba(rgba[0]),
    .o_pix_last(last[0]), .o_busy(busy[0]), .o_done(done[0]));

  sram_pixel_streamer #(.ADDR_W(20), .READ_LAT(LAT1), .FIFO_DEPTH(DEPTH)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_base_addr(base),
    .i_frame_words(words), .i_fmt(fmt), .i_loop(loop), .io_sram_data(bus1),
    .o_sram_addr(addr[1]), .o_pix_valid(valid[1]), .i_pix_ready(ready), .o_pix_rgba(rgba[1]),
    .o_pix_last(last[1]), .o_busy(busy[1]), .o_done(done[1]));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    for (int k = 0; k < 2; k++) begin
      if (addr[k] !== prev_addr[k]) issued[k]++;
      prev_addr[k] = addr[k];
      if (issued[k] - pops[k] > max_out[k]) max_out[k] = issued[k] - pops[k];
      if (valid[k] === 1'b1 && first_valid[k] < 0) first_valid[k] = cyc;
      if (done[k] === 1'b1) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      if (valid[k] === 1'b1 && ready) begin
        if (got_n[k] < 256) begin
          got_rgba[k][got_n[k]] = rgba[k];
          got_last[k][got_n[k]] = last[k];
          got_n[k]++;
        end
        pops[k]++;
        if (last[k] === 1'b1) last_pop_cyc[k] = cyc;
      end
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      got_n[k] = 0; issued[k] = 0; pops[k] = 0; max_out[k] = 0; done_cnt[k] = 0;
      done_cyc[k] = -1; last_pop_cyc[k] = -9; first_valid[k] = -1;
      prev_addr[k] = addr[k];
    end
  endtask

  task automatic begin_frame(input logic [19:0] b, input logic [19:0] w, input logic f, input logic l);
    base = b; words = w; fmt = f; loop = l;
    start = 1'b1;
    step();
    start = 1'b0;
    clear_stats();
  endtask

  task automatic run_idle(input int max, output bit timed_out);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((busy[0] === 1'b1 || busy[1] === 1'b1) && n < max);
    timed_out = (n >= max);
  endtask

  task automatic build_exp(input logic [19:0] b, input logic [19:0] w, input logic f, input int n);
    int wl;
    logic [19:0] a;
    wl = (w == 0) ? 1 : int'(w);
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      a = b + 20'(i % wl);
      exp_rgba[i] = ref_rgba(f, sram_word(a));
      exp_last[i] = ((i % wl) == wl - 1);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (addr[k] !== 20'h0) begin errors++; $display("FAIL reset_addr k=%0d got %h exp 0", k, addr[k]); end
      if (valid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid k=%0d got %b exp 0", k, valid[k]); end
      if (last[k] !== 1'b0) begin errors++; $display("FAIL reset_last k=%0d got %b exp 0", k, last[k]); end
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy k=%0d got %b exp 0", k, busy[k]); end
      if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done k=%0d got %b exp 0", k, done[k]); end
    end
  endtask

  task automatic test_oneshot_5551();
    ovr_base = 20'h00100; ovr_n = 4;
    ovr_word[0] = 16'hF801; ovr_word[1] = 16'h07C1; ovr_word[2] = 16'h003F; ovr_word[3] = 16'hFFFE;
    exp_rgba[0] = 32'hFF0000FF; exp_rgba[1] = 32'h00FF00FF; exp_rgba[2] = 32'h0000FFFF; exp_rgba[3] = 32'hFFFFFF00;
    exp_last[0] = 0; exp_last[1] = 0; exp_last[2] = 0; exp_last[3] = 1;
    rnd_ready = 0; ready_hold = 1; ready = 1;
    begin_frame(20'h00100, 20'd4, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (busy[k] !== 1'b1) begin errors++; $display("FAIL start_busy k=%0d got %b exp 1", k, busy[k]); end
      if (addr[k] !== 20'h00100) begin errors++; $display("FAIL start_addr k=%0d got %h exp 00100", k, addr[k]); end
    end
    run_idle(40, to);
    checks++;
    if (to) begin errors++; $display("FAIL oneshot_timeout got busy exp idle"); end
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (got_n[k] != 4) begin errors++; $display("FAIL oneshot_count k=%0d got %0d exp 4", k, got_n[k]); end
      if (first_valid[k] != ((k == 0) ? LAT0 : LAT1)) begin
        errors++; $display("FAIL first_valid k=%0d got %0d exp %0d", k, first_valid[k], (k == 0) ? LAT0 : LAT1);
      end
      if (done_cnt[k] != 1) begin errors++; $display("FAIL oneshot_done_cnt k=%0d got %0d exp 1", k, done_cnt[k]); end
      if (done_cyc[k] != last_pop_cyc[k] + 1) begin
        errors++; $display("FAIL done_timing k=%0d got %0d exp %0d", k, done_cyc[k], last_pop_cyc[k] + 1);
      end
      for (int i = 0; i < 4 && i < got_n[k]; i++) begin
        checks += 2;
        if (got_rgba[k][i] !== exp_rgba[i]) begin errors++; $display("FAIL rgb5551_pix k=%0d i=%0d got %h exp %h", k, i, got_rgba[k][i], exp_rgba[i]); end
        if (got_last[k][i] !== exp_last[i]) begin errors++; $display("FAIL rgb5551_last k=%0d i=%0d got %b exp %b", k, i, got_last[k][i], exp_last[i]); end
      end
    end
    ovr_n = 0;
  endtask

  task automatic test_rgb565();
    ovr_base = 20'h00300; ovr_n = 3;
    ovr_word[0] = 16'hF800; ovr_word[1] = 16'h07E0; ovr_word[2] = 16'h001F;
    exp_rgba[0] = 32'hFF0000FF; exp_rgba[1] = 32'h00FF00FF; exp_rgba[2] = 32'h0000FFFF;
    ready_hold = 1;
    begin_frame(20'h00300, 20'd3, 1'b1, 1'b0);
    run_idle(40, to);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (got_n[k] != 3) begin errors++; $display("FAIL rgb565_count k=%0d got %0d exp 3", k, got_n[k]); end
      if (got_last[k][2] !== 1'b1) begin errors++; $display("FAIL rgb565_last k=%0d got %b exp 1", k, got_last[k][2]); end
      for (int i = 0; i < 3 && i < got_n[k]; i++) begin
        checks++;
        if (got_rgba[k][i] !== exp_rgba[i]) begin errors++; $display("FAIL rgb565_pix k=%0d i=%0d got %h exp %h", k, i, got_rgba[k][i], exp_rgba[i]); end
      end
    end
    ovr_n = 0;
  endtask

  task automatic test_loop();
    logic [19:0] ea;
    ready_hold = 1;
    begin_frame(20'hFFFFE, 20'd3, 1'b0, 1'b1);
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step();
      ea = 20'hFFFFE + 20'(cyc % 3);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (addr[k] !== ea) begin errors++; $display("FAIL loop_addr k=%0d cyc=%0d got %h exp %h", k, cyc, addr[k], ea); end
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    build_exp(20'hFFFFE, 20'd3, 1'b0, 16);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL loop_abort_busy k=%0d got %b exp 0", k, busy[k]); end
      if (done_cnt[k] != 0) begin errors++; $display("FAIL loop_done k=%0d got %0d exp 0", k, done_cnt[k]); end
      if (got_n[k] != 13 - ((k == 0) ? LAT0 : LAT1)) begin
        errors++; $display("FAIL loop_throughput k=%0d got %0d exp %0d", k, got_n[k], 13 - ((k == 0) ? LAT0 : LAT1));
      end
      for (int i = 0; i < got_n[k] && i < exp_n; i++) begin
        checks++;
        if (got_rgba[k][i] !== exp_rgba[i] || got_last[k][i] !== exp_last[i]) begin
          errors++; $display("FAIL loop_pix k=%0d i=%0d got %h/%b exp %h/%b", k, i, got_rgba[k][i], got_last[k][i], exp_rgba[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    logic [19:0] b;
    logic        f;
    b = 20'($urandom);
    f = 1'($urandom_range(0, 1));
    rnd_ready = 0; ready_hold = 0; ready = 0;
    begin_frame(b, 20'd64, f, 1'b0);
    repeat (12) step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (issued[k] != DEPTH) begin errors++; $display("FAIL stall_issued k=%0d got %0d exp %0d", k, issued[k], DEPTH); end
      if (valid[k] !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d got %b exp 1", k, valid[k]); end
    end
    rnd_ready = 1;
    run_idle(2000, to);
    rnd_ready = 0; ready_hold = 1;
    checks++;
    if (to) begin errors++; $display("FAIL random_timeout got busy exp idle"); end
    build_exp(b, 20'd64, f, 64);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (got_n[k] != 64) begin errors++; $display("FAIL random_count k=%0d got %0d exp 64", k, got_n[k]); end
      if (max_out[k] > DEPTH) begin errors++; $display("FAIL random_credit k=%0d got %0d exp <=%0d", k, max_out[k], DEPTH); end
      if (done_cnt[k] != 1) begin errors++; $display("FAIL random_done k=%0d got %0d exp 1", k, done_cnt[k]); end
      for (int i = 0; i < got_n[k] && i < exp_n; i++) begin
        checks++;
        if (got_rgba[k][i] !== exp_rgba[i] || got_last[k][i] !== exp_last[i]) begin
          errors++; $display("FAIL random_pix k=%0d i=%0d got %h/%b exp %h/%b", k, i, got_rgba[k][i], got_last[k][i], exp_rgba[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    ready_hold = 0;
    begin_frame(20'h00040, 20'd32, 1'b0, 1'b0);
    repeat (3) step();
    abort = 1'b1; start = 1'b1; base = 20'h00999;
    step();
    abort = 1'b0; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (valid[k] !== 1'b0) begin errors++; $display("FAIL abort_valid k=%0d got %b exp 0", k, valid[k]); end
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL abort_busy k=%0d got %b exp 0", k, busy[k]); end
    end
    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL abort_start_ignored k=%0d got %b exp 0", k, busy[k]); end
      if (done_cnt[k] != 0) begin errors++; $display("FAIL abort_done k=%0d got %0d exp 0", k, done_cnt[k]); end
    end
    ready_hold = 1;
    begin_frame(20'h00200, 20'd8, 1'b1, 1'b0);
    run_idle(60, to);
    build_exp(20'h00200, 20'd8, 1'b1, 8);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (got_n[k] != 8) begin errors++; $display("FAIL restart_count k=%0d got %0d exp 8", k, got_n[k]); end
      if (done_cnt[k] != 1) begin errors++; $display("FAIL restart_done k=%0d got %0d exp 1", k, done_cnt[k]); end
      for (int i = 0; i < got_n[k] && i < exp_n; i++) begin
        checks++;
        if (got_rgba[k][i] !== exp_rgba[i] || got_last[k][i] !== exp_last[i]) begin
          errors++; $display("FAIL restart_pix k=%0d i=%0d got %h/%b exp %h/%b", k, i, got_rgba[k][i], got_last[k][i], exp_rgba[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    ready_hold = 1;
    begin_frame(20'h00500, 20'd6, 1'b0, 1'b0);
    repeat (2) step();
    base = 20'h00999; words = 20'd2; fmt = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run_idle(60, to);
    build_exp(20'h00500, 20'd6, 1'b0, 6);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_n[k] != 6) begin errors++; $display("FAIL busy_start_count k=%0d got %0d exp 6", k, got_n[k]); end
      for (int i = 0; i < got_n[k] && i < exp_n; i++) begin
        checks++;
        if (got_rgba[k][i] !== exp_rgba[i] || got_last[k][i] !== exp_last[i]) begin
          errors++; $display("FAIL busy_start_pix k=%0d i=%0d got %h/%b exp %h/%b", k, i, got_rgba[k][i], got_last[k][i], exp_rgba[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_zero_words();
    ready_hold = 1;
    begin_frame(20'h00700, 20'd0, 1'b1, 1'b0);
    run_idle(40, to);
    build_exp(20'h00700, 20'd0, 1'b1, 1);
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (got_n[k] != 1) begin errors++; $display("FAIL zero_count k=%0d got %0d exp 1", k, got_n[k]); end
      if (got_rgba[k][0] !== exp_rgba[0]) begin errors++; $display("FAIL zero_pix k=%0d got %h exp %h", k, got_rgba[k][0], exp_rgba[0]); end
      if (got_last[k][0] !== 1'b1) begin errors++; $display("FAIL zero_last k=%0d got %b exp 1", k, got_last[k][0]); end
      if (done_cnt[k] != 1) begin errors++; $display("FAIL zero_done k=%0d got %0d exp 1", k, done_cnt[k]); end
    end
  endtask

  task automatic test_async_reset();
    ready_hold = 0;
    begin_frame(20'h00800, 20'd16, 1'b0, 1'b0);
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (addr[k] !== 20'h0) begin errors++; $display("FAIL arst_addr k=%0d got %h exp 0", k, addr[k]); end
      if (valid[k] !== 1'b0) begin errors++; $display("FAIL arst_valid k=%0d got %b exp 0", k, valid[k]); end
      if (last[k] !== 1'b0) begin errors++; $display("FAIL arst_last k=%0d got %b exp 0", k, last[k]); end
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL arst_busy k=%0d got %b exp 0", k, busy[k]); end
      if (done[k] !== 1'b0) begin errors++; $display("FAIL arst_done k=%0d got %b exp 0", k, done[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fmt = 1'b0; loop = 1'b0; ready = 1'b0;
    base = '0; words = '0; ovr_base = '0; ovr_n = 0;
    rnd_ready = 0; ready_hold = 0;
    for (int i = 0; i < 8; i++) ovr_word[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
    test_reset();
    test_oneshot_5551();
    test_rgb565();
    test_loop();
    test_random_ready();
    test_abort();
    test_start_busy();
    test_zero_words();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
